seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Multiplexed hex seven-segment display driver that sits directly downstream of the 4-bit counters.
- Latches a packed NUM_DIGITS-nibble value on a load strobe and scans the digits one at a time, with a dead-time blank between digits to suppress ghosting.
- Decodes each nibble to active-low segments and drives active-low anodes to the board display.

Parameters:
- NUM_DIGITS, 4: number of digits scanned. Legal range 1..8.
- PRESCALE, 50000: clk cycles per digit slot. Must exceed BLANK_CYCLES; elaboration error otherwise.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  reset, synchronous, active-high.
- load  in  1  capture value and dp_in into the shadow registers at this edge.
- value  in  4*NUM_DIGITS  packed nibbles; digit 0 = value[3:0].
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- enable  in  1  0 = display dark, scan frozen.
- an  out  NUM_DIGITS  anodes, active-low, registered.
- seg  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- digit_idx  out  3  index of the digit in the current slot.
- frame_tick  out  1  one-cycle pulse when digit_idx wraps from NUM_DIGITS-1 to 0.

Behaviour:
- Single clock domain. arst is sampled only on a clk rising edge.
- Reset values:
  - an = all 1, seg = 7'h7F, dp = 1, digit_idx = 0, frame_tick = 0.
  - Shadow value = 0, shadow dp = 0.
  - Slot counter = 0, state = BLANK.
- Reset asserted mid-scan returns every register to its reset value at the next edge; no partial slot is completed.
- Shadow registers:
  - load = 1 captures value and dp_in at that edge.
  - The shadow is independent of enable and of the scan state.
- FSM has two states, with a slot counter (0..PRESCALE-1) incremented every enabled cycle:
  - BLANK: counter 0..BLANK_CYCLES-1. an = all 1, seg = 7'h7F, dp = 1.
  - DRIVE: counter BLANK_CYCLES..PRESCALE-1. an[digit_idx] = 0, all other anodes = 1. seg and dp come from the digit snapshot.
  - BLANK -> DRIVE when counter = BLANK_CYCLES-1.
  - DRIVE -> BLANK when counter = PRESCALE-1. On that edge the counter clears to 0 and digit_idx increments modulo NUM_DIGITS.
- Snapshot:
  - The digit nibble and dp are captured from the shadow on the BLANK -> DRIVE edge and held for the whole DRIVE phase.
  - A load during DRIVE affects only later slots.
  - A load on the same edge as BLANK -> DRIVE leaves that slot showing the old shadow value.
- Output timing:
  - an, seg and dp are registered and change on the same edge as the state change; no combinational path from the inputs.
  - First DRIVE cycle after reset release is cycle BLANK_CYCLES.
  - Digit period = PRESCALE cycles; frame = NUM_DIGITS*PRESCALE cycles.
- frame_tick is asserted in the cycle after the edge where digit_idx goes from NUM_DIGITS-1 to 0. It is never asserted while enable = 0.
- enable = 0: state forced to BLANK, counter held at 0, digit_idx holds its value, outputs dark. On re-enable, the scan resumes at BLANK with the same digit_idx.
- Hex decode table (seg, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- digit_idx upper bits beyond clog2(NUM_DIGITS) are tied to 0.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: at snapshot time, a digit whose own nibble and every higher nibble in the shadow are 0 is blanked for its DRIVE phase (an stays 1, seg = 7'h7F, dp = 1). Digit 0 is never blanked. Slot timing, digit_idx and frame_tick are unchanged.
- Undefined: every digit is driven, including leading zeros.

Test Plan (PRESCALE = 8, BLANK_CYCLES = 2, NUM_DIGITS = 4):
1. Reset, then load value = 16'h1234, dp_in = 0 -> slots show:
   - digit0: an = 1110, seg = 19
   - digit1: an = 1101, seg = 30
   - digit2: an = 1011, seg = 24
   - digit3: an = 0111, seg = 79
   - Each digit is driven 6 cycles after 2 blank cycles; frame_tick pulses once every 32 cycles.
2. Load 16'hABCD during the DRIVE of digit1 -> digit1 finishes showing 3; digit2 shows B (03) in its next slot.
3. Load on the exact BLANK -> DRIVE edge of digit0 -> old digit0 nibble displayed for that slot; new nibble shown one frame later.
4. Deassert enable for 20 cycles mid-DRIVE of digit2 -> outputs go dark on the next edge and frame_tick stays 0. After re-enable: 2 blank cycles, then digit2 is driven for 6 cycles.
5. Assert arst for 1 cycle mid-DRIVE of digit3 -> next edge: an = 1111, seg = 7F, digit_idx = 0, shadow = 0. Then digit0 shows 0 (40) from cycle 2 after release.
6. With SEG7_LEADING_ZERO_BLANK_EN, load 16'h0050 -> digit3 and digit2 dark; digit1 shows 5 (12); digit0 shows 0 (40). Without the macro, all four digits are driven.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed hex seven-segment driver. A packed NUM_DIGITS-nibble value is
// latched into a shadow register on `load`, and the digits are scanned one
// slot at a time. Each slot opens with BLANK_CYCLES of dark anodes to suppress
// ghosting, then drives one digit for the rest of the PRESCALE-cycle slot.
// Segments, decimal point and anodes are all active-low and registered.
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (the digit's own nibble and every higher
//   nibble are zero) stay dark for their slot. Digit 0 is always driven.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    enable,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [2:0]              digit_idx,
  output logic                    frame_tick
);

  // Parameter legality, rejected at elaboration.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg7_scan_driver: BLANK_CYCLES must be at least 1");
  end
  if (PRESCALE <= BLANK_CYCLES) begin : g_bad_prescale
    $error("seg7_scan_driver: PRESCALE must exceed BLANK_CYCLES");
  end

  localparam int                  CW         = $clog2(PRESCALE);
  localparam logic [CW-1:0]       CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]       CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]       CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]       BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]          IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
  localparam logic [6:0]          SEG_OFF    = 7'h7F;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;

  // Shadow padded to eight digits so a 3-bit index always selects in range.
  logic [31:0]             val_pad_s;
  logic [7:0]              dp_pad_s;
  logic [3:0]              nib_s;
  logic [NUM_DIGITS-1:0]   an_drive_s;
  logic                    suppress_s;

  assign val_pad_s = 32'(shadow_val_q);
  assign dp_pad_s  = 8'(shadow_dp_q);
  assign nib_s     = val_pad_s[{idx_q, 2'b00} +: 4];

  // One-cold anode pattern for the digit owning the current slot.
  always_comb begin
    an_drive_s = AN_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        an_drive_s[i] = 1'b0;
      end else begin
        an_drive_s[i] = 1'b1;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [7:0] lz_s;

  // Flag each position whose own nibble and all higher nibbles are zero.
  always_comb begin
    logic run_v;
    lz_s  = 8'h00;
    run_v = 1'b1;
    for (int j = 7; j >= 0; j--) begin
      run_v   = run_v & (val_pad_s[4*j +: 4] == 4'h0);
      lz_s[j] = run_v;
    end
  end

  assign suppress_s = lz_s[idx_q] & (idx_q != 3'd0);
`else
  assign suppress_s = 1'b0;
`endif

  // Shadow capture: independent of enable and of the scan position.
  always_ff @(posedge clk) begin
    if (arst) begin
      shadow_val_q <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_q  <= {NUM_DIGITS{1'b0}};
    end else if (load) begin
      shadow_val_q <= value;
      shadow_dp_q  <= dp_in;
    end else begin
      shadow_val_q <= shadow_val_q;
      shadow_dp_q  <= shadow_dp_q;
    end
  end

  // Scan sequencing; display outputs are computed for the coming cycle so
  // they change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    tick_d  = 1'b0;
    if (!enable) begin
      state_d = ST_BLANK;
      cnt_d   = CNT_ZERO;
      an_d    = AN_OFF;
      seg_d   = SEG_OFF;
      dp_d    = 1'b1;
    end else begin
      case (state_q)
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            // Snapshot taken from the shadow as it stood before this edge.
            if (suppress_s) begin
              an_d  = AN_OFF;
              seg_d = SEG_OFF;
              dp_d  = 1'b1;
            end else begin
              an_d  = an_drive_s;
              seg_d = hex_to_seg(nib_s);
              dp_d  = ~dp_pad_s[idx_q];
            end
          end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = CNT_ZERO;
            an_d    = AN_OFF;
            seg_d   = SEG_OFF;
            dp_d    = 1'b1;
            if (idx_q == IDX_LAST) begin
              idx_d  = 3'd0;
              tick_d = 1'b1;
            end else begin
              idx_d  = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = CNT_ZERO;
          an_d    = AN_OFF;
          seg_d   = SEG_OFF;
          dp_d    = 1'b1;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= ST_BLANK;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 3'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  // The wrap pulse is masked while the display is disabled.
  assign frame_tick = tick_q & enable;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, PRESCALE=8,
// BLANK_CYCLES=2). The reference model tracks slot position and digit with
// modular arithmetic and decodes from a lookup table.
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst, load, enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  digit_idx;
  logic        frame_tick;
  logic [15:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // Reference model state.
  int          m_pos, m_dig;
  logic [15:0] m_shadow;
  logic [3:0]  m_sdp;
  logic        m_tick;
  logic [3:0]  s_nib;
  logic        s_dp, s_blank;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .arst(arst), .load(load), .value(value), .dp_in(dp_in),
    .enable(enable), .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  assign obs = {an, seg, dp, digit_idx, frame_tick};

  // Advance one clock and apply the inputs seen at that edge to the model.
  task automatic cyc();
    logic [15:0] old_sh;
    logic [3:0]  old_dp;
    @(posedge clk);
    #1;
    cyc_no++;
    if (arst) begin
      m_pos = 0; m_dig = 0; m_shadow = 16'h0; m_sdp = 4'h0; m_tick = 1'b0;
      s_nib = 4'h0; s_dp = 1'b0; s_blank = 1'b0;
    end else begin
      old_sh = m_shadow;
      old_dp = m_sdp;
      if (load) begin
        m_shadow = value;
        m_sdp    = dp_in;
      end
      if (!enable) begin
        m_pos  = 0;
        m_tick = 1'b0;
      end else begin
        m_tick = (m_pos == P - 1) && (m_dig == N - 1);
        if (m_pos == P - 1) begin
          m_pos = 0;
          m_dig = (m_dig + 1) % N;
        end else begin
          m_pos = m_pos + 1;
        end
        if (m_pos == B) begin
          s_nib   = 4'((old_sh >> (4 * m_dig)) & 16'hF);
          s_dp    = old_dp[m_dig];
          s_blank = LZ_EN && (m_dig != 0) && ((old_sh >> (4 * m_dig)) == 16'h0);
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_vec();
    logic       dark;
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    dark = (m_pos < B) || s_blank;
    if (dark) begin
      a = 4'hF; s = 7'h7F; d = 1'b1;
    end else begin
      a = ~(4'b0001 << m_dig); s = seg_tab[s_nib]; d = ~s_dp;
    end
    return {a, s, d, 3'(m_dig), m_tick & enable};
  endfunction

  // Move forward until the model sits at digit d, slot position p.
  task automatic wait_slot(input int d, input int p);
    int k;
    k = 0;
    while (!(m_dig == d && m_pos == p) && k < 200) begin
      cyc();
      k++;
    end
    if (k >= 200) begin
      $display("FAIL wait_slot timeout d=%0d p=%0d", d, p);
      $fatal(1, "bench stalled");
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; load = 1'b0; enable = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if (obs !== {4'hF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_state got=%h exp=%h", obs, {4'hF, 7'h7F, 1'b1, 3'd0, 1'b0});
      end
    end
    arst = 1'b0;
  endtask

  task automatic test_basic_scan();
    logic [6:0] exp1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    int t0, nt;
    t0 = -1; nt = 0;
    load = 1'b1; value = 16'h1234; dp_in = 4'h0;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 70; i++) begin
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_scan cyc=%0d got=%h exp=%h", cyc_no, obs, exp_vec());
      end
      if (m_pos == B) begin
        n_checks++;
        if (seg !== exp1234[m_dig] || an !== ~(4'b0001 << m_dig)) begin
          n_fail++;
          $display("FAIL basic_digit d=%0d got an=%b seg=%h exp seg=%h", m_dig, an, seg, exp1234[m_dig]);
        end
      end
      if (frame_tick === 1'b1) begin
        if (nt == 1) begin
          n_checks++;
          if (cyc_no - t0 != N * P) begin
            n_fail++;
            $display("FAIL frame_period got=%0d exp=%0d", cyc_no - t0, N * P);
          end
        end
        if (nt == 0) t0 = cyc_no;
        nt++;
      end
    end
    n_checks++;
    if (nt < 2) begin
      n_fail++;
      $display("FAIL frame_tick_count got=%0d exp>=2", nt);
    end
  endtask

  task automatic test_load_during_drive();
    wait_slot(1, 4);
    load = 1'b1; value = 16'hABCD;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL load_in_drive cyc=%0d got=%h exp=%h", cyc_no, obs, exp_vec());
      end
      if (m_dig == 1 && m_pos >= B) begin
        n_checks++;
        if (seg !== 7'h30) begin
          n_fail++;
          $display("FAIL digit1_keeps_old got=%h exp=30", seg);
        end
      end
      if (m_dig == 2 && m_pos >= B) begin
        n_checks++;
        if (seg !== 7'h03 || an !== 4'b1011) begin
          n_fail++;
          $display("FAIL digit2_new got an=%b seg=%h exp an=1011 seg=03", an, seg);
        end
      end
      cyc();
    end
  endtask

  task automatic test_load_on_snapshot();
    wait_slot(0, B - 1);
    load = 1'b1; value = 16'h5678;
    cyc();
    load = 1'b0;
    n_checks++;
    if (seg !== 7'h21 || an !== 4'b1110) begin
      n_fail++;
      $display("FAIL snap_edge_old got an=%b seg=%h exp an=1110 seg=21", an, seg);
    end
    for (int i = 0; i < N * P; i++) begin
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL snap_frame cyc=%0d got=%h exp=%h", cyc_no, obs, exp_vec());
      end
    end
    n_checks++;
    if (seg !== 7'h00 || an !== 4'b1110) begin
      n_fail++;
      $display("FAIL snap_edge_new got an=%b seg=%h exp an=1110 seg=00", an, seg);
    end
  endtask

  task automatic test_enable_gap();
    wait_slot(2, 4);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if (an !== 4'hF || seg !== 7'h7F || frame_tick !== 1'b0 || digit_idx !== 3'd2 || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL enable_dark cyc=%0d got=%h exp=%h", cyc_no, obs, exp_vec());
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_checks++;
      if (i >= 1 && i <= 6) begin
        if (an !== 4'b1011 || seg !== 7'h02 || obs !== exp_vec()) begin
          n_fail++;
          $display("FAIL reenable_drive i=%0d got=%h exp an=1011 seg=02", i, obs);
        end
      end else begin
        if (an !== 4'hF || obs !== exp_vec()) begin
          n_fail++;
          $display("FAIL reenable_blank i=%0d got=%h exp=%h", i, obs, exp_vec());
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    wait_slot(3, 4);
    arst = 1'b1;
    cyc();
    arst = 1'b0;
    n_checks++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid got=%h exp=%h", obs, {4'hF, 7'h7F, 1'b1, 3'd0, 1'b0});
    end
    for (int i = 0; i < N * P; i++) begin
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc_no, obs, exp_vec());
      end
      if (i == 1) begin
        n_checks++;
        if (an !== 4'b1110 || seg !== 7'h40) begin
          n_fail++;
          $display("FAIL reset_digit0 got an=%b seg=%h exp an=1110 seg=40", an, seg);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] exp0050 [4] = '{7'h40, 7'h12, 7'h40, 7'h40};
    arst = 1'b1;
    cyc();
    arst = 1'b0; load = 1'b1; value = 16'h0050; dp_in = 4'h0;
    cyc();
    load = 1'b0;
    for (int i = 0; i < N * P; i++) begin
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL lz_scan cyc=%0d got=%h exp=%h", cyc_no, obs, exp_vec());
      end
      if (m_pos == B + 1) begin
        n_checks++;
        if (LZ_EN && m_dig >= 2) begin
          if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL lz_dark d=%0d got an=%b seg=%h exp an=1111 seg=7f", m_dig, an, seg);
          end
        end else begin
          if (an !== ~(4'b0001 << m_dig) || seg !== exp0050[m_dig]) begin
            n_fail++;
            $display("FAIL lz_driven d=%0d got an=%b seg=%h exp seg=%h", m_dig, an, seg, exp0050[m_dig]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      arst   = ($urandom_range(0, 99) == 0);
      load   = ($urandom_range(0, 7) == 0);
      value  = 16'($urandom);
      dp_in  = 4'($urandom);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      cyc();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc_no, obs, exp_vec());
      end
    end
    arst = 1'b0; load = 1'b0; enable = 1'b1;
  endtask

  initial begin
    m_pos = 0; m_dig = 0; m_shadow = 16'h0; m_sdp = 4'h0; m_tick = 1'b0;
    s_nib = 4'h0; s_dp = 1'b0; s_blank = 1'b0;
    arst = 1'b1; load = 1'b0; enable = 1'b1; value = 16'h0; dp_in = 4'h0;
    test_reset();
    test_basic_scan();
    test_load_during_drive();
    test_load_on_snapshot();
    test_enable_gap();
    test_reset_mid_scan();
    test_leading_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
